// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch request (fetch unit -> memory)
//   imem_addr  : fetch address (fetch unit -> memory)
//   imem_ready : response valid, imem_rdata valid this cycle (memory -> fetch unit)
//   imem_rdata : instruction word (memory -> fetch unit)
// master = fetch unit side, slave = memory side.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over the imem handshake,
// holds the word in instr until downstream acks, then picks the next PC
// (jump > branch > sequential) and counts retired instructions.
// Ports:
//   clk, reset         : clock, synchronous active-low reset
//   imem               : fetch bus (master side)
//   instr, instr_valid : instruction register and its valid flag
//   instr_ack          : downstream finished the instruction in instr
//   branch_taken, branch_target, jump : next-PC controls, sampled at ack
//   pc, pcplus4        : current PC and pc+4
//   retired            : acknowledged-instruction counter (wraps)
// Jump target slicing assumes WIDTH >= 32.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_if.master     imem,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ack,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcplus4,
  output logic [31:0]      retired
);
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~{{(WIDTH-2){1'b0}}, 2'b11};

  logic [1:0]       state;
  logic [WIDTH-1:0] next_pc;

  assign pcplus4        = pc + WIDTH'(4);
  assign imem.imem_addr = pc;
  assign imem.imem_req  = (state == FETCH);
  assign instr_valid    = (state == HOLD);

  // Jump keeps the PC region bits of pc+4; branch targets are word-aligned
  // by dropping the low two bits.
  always_comb begin
    next_pc = pcplus4;
    if (jump)              next_pc = {pcplus4[WIDTH-1:28], instr[25:0], 2'b00};
    else if (branch_taken) next_pc = branch_target & ALIGN_MASK;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      case (state)
        BOOT:  state <= FETCH;
        FETCH: if (imem.imem_ready) begin
          instr <= imem.imem_rdata;
          state <= HOLD;
        end
        HOLD:  if (instr_ack) begin
          pc      <= next_pc;
          retired <= retired + 32'd1;
          state   <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ready, ack, br, jmp;
  logic [31:0] rdata, bt;

  int checks = 0;
  int failures = 0;

  // two instances: one booting at 0, one booting at the top word (wrap case)
  logic [31:0] instr_o [2];
  logic        valid_o [2];
  logic [31:0] pc_o    [2];
  logic [31:0] pc4_o   [2];
  logic [31:0] ret_o   [2];
  logic        req_o   [2];
  logic [31:0] addr_o  [2];

  fetch_unit_if #(.WIDTH(32)) if0 ();
  fetch_unit_if #(.WIDTH(32)) if1 ();
  assign if0.imem_ready = ready;
  assign if0.imem_rdata = rdata;
  assign if1.imem_ready = ready;
  assign if1.imem_rdata = rdata;
  assign req_o[0]  = if0.imem_req;
  assign addr_o[0] = if0.imem_addr;
  assign req_o[1]  = if1.imem_req;
  assign addr_o[1] = if1.imem_addr;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset(rst_n), .imem(if0), .instr(instr_o[0]), .instr_valid(valid_o[0]),
    .instr_ack(ack), .branch_taken(br), .branch_target(bt), .jump(jmp),
    .pc(pc_o[0]), .pcplus4(pc4_o[0]), .retired(ret_o[0]));

  fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(rst_n), .imem(if1), .instr(instr_o[1]), .instr_valid(valid_o[1]),
    .instr_ack(ack), .branch_taken(br), .branch_target(bt), .jump(jmp),
    .pc(pc_o[1]), .pcplus4(pc4_o[1]), .retired(ret_o[1]));

  // ---------------- behavioural model ----------------
  // phase: 0 = booting, 1 = waiting for memory, 2 = holding an instruction
  int          m_ph  [2];
  logic [31:0] m_pc  [2];
  logic [31:0] m_ins [2];
  logic [31:0] m_ret [2];
  bit          model_ok = 0;

  function automatic logic [31:0] reset_pc(int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ph[k] = 0; m_pc[k] = reset_pc(k); m_ins[k] = 0; m_ret[k] = 0;
      end else if (m_ph[k] == 0) begin
        m_ph[k] = 1;
      end else if (m_ph[k] == 1) begin
        if (ready) begin m_ins[k] = rdata; m_ph[k] = 2; end
      end else if (ack) begin
        if (jmp)
          m_pc[k] = ((m_pc[k] + 32'd4) & 32'hF000_0000) | ((m_ins[k] & 32'h03FF_FFFF) * 4);
        else if (br)
          m_pc[k] = (bt / 4) * 4;
        else
          m_pc[k] = m_pc[k] + 32'd4;
        m_ret[k] = m_ret[k] + 1;
        m_ph[k] = 1;
      end
    end
    if (!rst_n) model_ok = 1;
  end

  task automatic cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d] t=%0t got=%h expected=%h", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        cmp("m_req",   k, 32'(req_o[k]),   32'(m_ph[k] == 1));
        cmp("m_valid", k, 32'(valid_o[k]), 32'(m_ph[k] == 2));
        cmp("m_pc",    k, pc_o[k],  m_pc[k]);
        cmp("m_addr",  k, addr_o[k], m_pc[k]);
        cmp("m_pc4",   k, pc4_o[k], m_pc[k] + 32'd4);
        cmp("m_instr", k, instr_o[k], m_ins[k]);
        cmp("m_ret",   k, ret_o[k], m_ret[k]);
      end
    end
  end

  // ---------------- directed literal pins + random ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; ready = 0; rdata = 0; ack = 0; br = 0; bt = 0; jmp = 0;
    step(); step();
    chk("rst_req", 32'(req_o[0]), 0);
    chk("rst_valid", 32'(valid_o[0]), 0);
    chk("rst_pc0", pc_o[0], 32'h0);
    chk("rst_pc1", pc_o[1], 32'hFFFF_FFFC);
    chk("rst_instr", instr_o[0], 32'h0);
    chk("rst_ret", ret_o[0], 32'h0);

    // sequential fetch with memory and ack always ready
    rst_n = 1; ready = 1; ack = 1; rdata = 32'h2000_0001;
    step();
    chk("t1_req0", 32'(req_o[0]), 1);
    chk("t1_addr0", addr_o[0], 32'h0);
    step();
    chk("t1_hold_req", 32'(req_o[0]), 0);
    chk("t1_hold_valid", 32'(valid_o[0]), 1);
    step();
    chk("t1_addr4", addr_o[0], 32'h4);
    chk("t1_wrap_pc1", pc_o[1], 32'h0);
    step(); step();
    chk("t1_addr8", addr_o[0], 32'h8);
    step(); step();
    chk("t1_ret3", ret_o[0], 32'd3);
    chk("t1_pcC", pc_o[0], 32'hC);

    // memory stalls 3 cycles
    ready = 0; ack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req_stall", 32'(req_o[0]), 1);
      chk("t2_addr_stall", addr_o[0], 32'hC);
    end
    ready = 1; rdata = 32'h8C08_0004;
    step();
    chk("t2_instr", instr_o[0], 32'h8C08_0004);
    chk("t2_valid", 32'(valid_o[0]), 1);

    // branch into upper region, then jump keeps the region bits
    ready = 0; br = 1; bt = 32'hF000_0013; ack = 1;
    step();
    chk("t3_br_hi", pc_o[0], 32'hF000_0010);
    br = 0; ack = 0; ready = 1; rdata = 32'h0800_0040;
    step();
    jmp = 1; br = 1; bt = 32'h100; ack = 1; ready = 0;
    step();
    chk("t3_jmp_hi", pc_o[0], 32'hF000_0100);
    jmp = 0; br = 0; ack = 0; ready = 1; rdata = 32'h0;
    step();
    br = 1; bt = 32'h10; ack = 1; ready = 0;
    step();
    chk("t3_br_10", pc_o[0], 32'h10);
    br = 0; ack = 0; ready = 1; rdata = 32'h0800_0040;
    step();
    jmp = 1; br = 1; bt = 32'h100; ack = 1; ready = 0;
    step();
    chk("t3_jmp_lo", pc_o[0], 32'h100);
    chk("t3_ret", ret_o[0], 32'd7);

    // branch alignment, and branch ignored outside HOLD
    jmp = 0; br = 0; ack = 0; ready = 1; rdata = 32'h0;
    step();
    br = 1; bt = 32'h203; ack = 1; ready = 0;
    step();
    chk("t4_br_align", pc_o[0], 32'h200);
    br = 1; bt = 32'h500; ack = 0; ready = 0;
    step();
    br = 0; ready = 1; rdata = 32'hA5A5_0001;
    step();
    ack = 1; ready = 0;
    step();
    chk("t4_br_ignored", pc_o[0], 32'h204);
    chk("t4_ret", ret_o[0], 32'd9);

    // long hold without ack; memory chatter ignored
    ack = 0; ready = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      rdata = $urandom;
      step();
      chk("t5_pc", pc_o[0], 32'h204);
      chk("t5_instr", instr_o[0], 32'hA5A5_0001);
      chk("t5_ret", ret_o[0], 32'd9);
    end

    // reset arriving with a memory response in the same cycle
    ack = 1; ready = 0;
    step();
    rst_n = 0; ready = 1; rdata = 32'hDEAD_BEEF;
    step();
    chk("t6_instr", instr_o[0], 32'h0);
    chk("t6_pc", pc_o[0], 32'h0);
    chk("t6_pc1", pc_o[1], 32'hFFFF_FFFC);
    chk("t6_ret", ret_o[0], 32'h0);
    chk("t6_req", 32'(req_o[0]), 0);
    rst_n = 1; ready = 0; ack = 0;
    step();
    chk("t6_refetch_req", 32'(req_o[0]), 1);
    chk("t6_refetch_addr", addr_o[0], 32'h0);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      ready = ($urandom_range(0, 2) != 0);
      ack   = ($urandom_range(0, 2) != 0);
      br    = $urandom_range(0, 1);
      jmp   = ($urandom_range(0, 3) == 0);
      bt    = $urandom;
      rdata = $urandom;
      step();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the main decoder. It owns the PC register and issues requests to instruction memory over a ready-handshake. It holds the fetched word in an instruction register, whose op field (instr[31:26]) drives the decoder. On each instruction-complete acknowledge it selects the next PC from sequential, branch or jump targets, and counts retired instructions.

Parameters:
WIDTH, 32, datapath/PC/instruction width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  WIDTH  fetch address, equals pc
imem_ready  input  1  memory response valid; imem_rdata valid this cycle
imem_rdata  input  WIDTH  instruction word from memory
instr  output  WIDTH  instruction register; instr[31:26] feeds decoder op
instr_valid  output  1  instr holds a fetched, unconsumed instruction
instr_ack  input  1  downstream has completed the instruction in instr
branch_taken  input  1  branch condition met (branch AND zero/not-zero from datapath)
branch_target  input  WIDTH  branch target address from datapath
jump  input  1  decoded jump control
pc  output  WIDTH  current PC
pcplus4  output  WIDTH  pc + 4, modulo 2^WIDTH
retired  output  32  count of acknowledged instructions

Behaviour:
- States: BOOT, FETCH, HOLD.
- Reset (reset==0 at a rising edge):
  - state=BOOT, pc=RESET_PC, instr=0, retired=0.
  - Any in-flight fetch is abandoned; an imem_ready arriving in the reset cycle is ignored.
- BOOT: imem_req=0, instr_valid=0. Unconditionally moves to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ready=1: instr<=imem_rdata, state<=HOLD.
  - Otherwise stay in FETCH with the address held stable.
- HOLD: imem_req=0, instr_valid=1, instr stable.
  - On instr_ack=1: pc<=next_pc, retired<=retired+1 (wraps at 2^32), state<=FETCH.
  - Otherwise stay in HOLD.
- next_pc priority:
  - jump=1: {pcplus4[31:28], instr[25:0], 2'b00}. Jump wins over branch_taken when both are asserted.
  - else branch_taken=1: {branch_target[31:2], 2'b00}, i.e. low two bits forced to zero.
  - else pcplus4.
- pcplus4 is combinational pc+4. PC 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Sampling windows:
  - jump, branch_taken and branch_target are sampled only in HOLD with instr_ack=1; ignored at all other times.
  - imem_ready outside FETCH is ignored.
  - instr_ack outside HOLD is ignored and does not increment retired.
- Minimum per-instruction latency, with imem_ready already high on entry to FETCH: 2 cycles (FETCH, HOLD with ack). Reset release to first imem_req takes 1 cycle (BOOT).
- Outputs pc, instr and retired are registered. imem_req and instr_valid decode state only. There are no combinational paths from inputs to outputs except imem_addr=pc and pcplus4.

Test Plan:
1. Reset release, RESET_PC=0, imem_ready=1 every cycle, instr_ack=1 whenever instr_valid, no branch/jump -> imem_addr sequence 0x0, 0x4, 0x8 on successive FETCH cycles; retired=3 after third ack; imem_req=0 during BOOT and HOLD.
2. imem_ready withheld 3 cycles in FETCH, then rdata=32'h8C08_0004 -> imem_req=1 and imem_addr stable for 4 cycles; instr=32'h8C08_0004 with instr_valid=1 the next cycle.
3. pc=0x0000_0010, instr=32'h0800_0040 (J), jump=1 with branch_taken=1 and branch_target=0x100 at ack -> next pc=0x0000_0100 from the jump field; verify with pc=0xF000_0010 -> 0xF000_0100 (upper bits preserved).
4. branch_taken=1, branch_target=0x0000_0203 at ack -> pc=0x0000_0200. branch_taken pulsed while in FETCH -> no effect, pc advances by 4.
5. pc forced to 0xFFFF_FFFC by reset with RESET_PC=32'hFFFF_FFFC, sequential ack -> pc=0x0000_0000. Hold instr_ack=0 for 5 cycles in HOLD -> pc, instr and retired unchanged.
6. reset=0 asserted during FETCH with imem_ready=1 in the same cycle -> instr stays 0, pc=RESET_PC, retired=0, state BOOT (imem_req=0) next cycle, re-fetch from RESET_PC after release.
